// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi decoder datapath: frame sequencer states and
// default trellis constants used by the ACS, SPMU and frame controller.
package viterbi_pkg;

  localparam int unsigned TbDepthDef = 8;
  localparam int unsigned TailLenDef = 2;
  localparam int unsigned PmW        = 8;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StAcq,
    StFlush,
    StDone
  } vit_state_e;

endpackage

// File: rtl/vit_tag_shift.sv
// Enable-gated 1-bit shift register tracking which trellis steps carry info bits.
// The MSB is the tag of the step whose SPMU decision is emerging now.
module vit_tag_shift #(
  parameter int unsigned Depth = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_din,
  output logic o_msb
);

  logic [Depth-1:0] sr_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sr_q <= '0;
    end else if (i_clr) begin
      sr_q <= '0;
    end else if (i_en) begin
      sr_q <= {sr_q[Depth-2:0], i_din};
    end
  end

  assign o_msb = sr_q[Depth-1];

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer: accepts one frame of coded symbols, clears path metrics, injects
// zero-tail/flush steps and emits exactly frame-length decoded bits before done.
module viterbi_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned TB_DEPTH = TbDepthDef,
  parameter int unsigned TAIL_LEN = TailLenDef
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_frame_len,
  input  logic             i_sym_valid,
  output logic             o_sym_ready,
  output logic             o_pm_clr,
  output logic             o_dp_valid,
  output logic             o_dp_flush,
  input  logic             i_dec_bit,
  output logic             o_bit_valid,
  output logic             o_bit,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam int unsigned FlSteps = TAIL_LEN + TB_DEPTH;
  localparam int unsigned FlW     = $clog2(FlSteps + 1);

  vit_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] in_cnt_q, in_cnt_d;
  logic [LEN_W-1:0] out_cnt_q, out_cnt_d;
  logic [FlW-1:0]   fl_cnt_q, fl_cnt_d;
  logic             err_q, err_d;
  logic             tag_msb;
  logic             handshake;

  assign o_busy      = (state_q != StIdle);
  assign o_pm_clr    = (state_q == StClr);
  assign o_sym_ready = (state_q == StAcq);
  assign o_dp_flush  = (state_q == StFlush);
  assign o_done      = (state_q == StDone);
  assign o_dp_valid  = (o_sym_ready & i_sym_valid) | o_dp_flush;
  assign o_err       = err_q;
  assign handshake   = o_sym_ready & i_sym_valid;

  assign o_bit_valid = o_dp_valid & tag_msb;
  // Gated so the output reads 0 outside valid decoded bits, including during reset.
  assign o_bit       = i_dec_bit & o_bit_valid;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    fl_cnt_d  = fl_cnt_q;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          if (i_frame_len != '0) begin
            len_d   = i_frame_len;
            state_d = StClr;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StClr: begin
        in_cnt_d  = '0;
        out_cnt_d = '0;
        fl_cnt_d  = '0;
        state_d   = StAcq;
      end
      StAcq: begin
        if (handshake) begin
          in_cnt_d = in_cnt_q + LEN_W'(1);
          if (in_cnt_q == len_q - LEN_W'(1)) begin
            fl_cnt_d = '0;
            state_d  = StFlush;
          end
        end
      end
      StFlush: begin
        fl_cnt_d = fl_cnt_q + FlW'(1);
        if (fl_cnt_q == FlW'(FlSteps - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A start request during a frame is rejected without disturbing it.
    if (o_busy && i_start) begin
      err_d = 1'b1;
    end
    if (o_bit_valid) begin
      out_cnt_d = out_cnt_q + LEN_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      fl_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      fl_cnt_q  <= fl_cnt_d;
      err_q     <= err_d;
    end
  end

  // Info steps are tagged 1; tail/flush steps shift in 0.
  vit_tag_shift #(
    .Depth (TB_DEPTH)
  ) u_tag_shift (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (o_pm_clr),
    .i_en    (o_dp_valid),
    .i_din   (o_sym_ready),
    .o_msb   (tag_msb)
  );

`ifndef SYNTHESIS
  a_out_cnt_at_done : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state_q == StDone) |-> (out_cnt_q == len_q));
`endif

endmodule
